pipe_stall_ctrl: RTL and testbench

Central pipeline stall/flush sequencer for the six-stage OpenMIPS pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB, WB).
- Merges level stall requests from ID and EX.
- Sequences multi-cycle EX operations (madd/msub/div) with an internal down-counter.
- Drives the stall[5:0] vector consumed by every pipeline register; EX/MEM inserts a bubble when stall[3]=Stop and stall[4]=NoStop.
- Handles flush abort.

---
 rtl/pipe_stall_ctrl.sv | 133 +++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// ============================================================================
// pipe_stall_ctrl
// ----------------------------------------------------------------------------
// Central stall/flush sequencer for the six-stage pipeline
// (PC, IF/ID, ID/EX, EX/MEM, MEM/WB, WB).
//
// - Merges the level stall requests from ID and EX.
// - Sequences multi-cycle EX operations (madd/msub/div) with a remaining-cycle
//   down-counter. An op of length N stalls exactly N cycles, counting the
//   start cycle.
// - Drives the stall vector read by every pipeline register. EX-level stalls
//   hold EX/MEM but not MEM/WB, so EX/MEM inserts a bubble.
// - Aborts any multi-cycle op on flush_req and emits a one-cycle flush strobe.
//
// Optional feature (macro STALL_PERF_CNT_EN):
//   defined   -> stall_perf_cnt counts cycles with stall[0]=1 and saturates
//                at all-ones; only rst clears it.
//   undefined -> no counter logic; stall_perf_cnt is tied to 0.
//
// Ports:
//   clk              in   clock
//   rst              in   synchronous, active-high reset
//   stallreq_from_id in   level stall request from ID (load-use etc.)
//   stallreq_from_ex in   level stall request from EX (single-cycle hazards)
//   ex_mc_start      in   one-cycle pulse: EX begins a multi-cycle op
//   ex_mc_cycles     in   stall length N of that op, sampled with ex_mc_start
//   flush_req        in   one-cycle pulse: abort and flush the pipeline
//   stall[5:0]       out  1 = Stop; bit0=PC ... bit5=WB
//   flush            out  registered flush strobe
//   ex_mc_busy       out  high while a multi-cycle op is being sequenced
//   ex_mc_done       out  pulse in the first cycle after the op's last stall
//   stall_perf_cnt   out  stalled-cycle counter (see optional feature)
// ============================================================================
module pipe_stall_ctrl #(
    parameter int MC_CNT_W = 6,
    parameter int PERF_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_from_id,
    input  logic                stallreq_from_ex,
    input  logic                ex_mc_start,
    input  logic [MC_CNT_W-1:0] ex_mc_cycles,
    input  logic                flush_req,
    output logic [5:0]          stall,
    output logic                flush,
    output logic                ex_mc_busy,
    output logic                ex_mc_done,
    output logic [PERF_W-1:0]   stall_perf_cnt
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] MC_BUSY = 1'b1;

    // Stall encodings: EX-level holds everything up to EX/MEM.
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    localparam logic [MC_CNT_W-1:0] ONE = MC_CNT_W'(1);

    logic [0:0]          state;
    logic [MC_CNT_W-1:0] rem;

    assign ex_mc_busy = (state == MC_BUSY);

    // Combinational stall vector, masked by rst and by a flush request.
    always_comb begin
        // NOTE: assign a default first so every path drives stall; otherwise
        // the incomplete if/else chain infers a latch.
        stall = STALL_NONE;
        if (rst || flush_req) begin
            stall = STALL_NONE;
        end else if (state == MC_BUSY) begin
            stall = STALL_EX;
        end else if (stallreq_from_ex || (ex_mc_start && ex_mc_cycles != '0)) begin
            stall = STALL_EX;
        end else if (stallreq_from_id) begin
            stall = STALL_ID;
        end
    end

    // Sequencer: state, remaining-cycle counter, flush strobe and done pulse.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all registers update together
        // from the pre-edge values, regardless of statement order.
        if (rst) begin
            state      <= IDLE;
            rem        <= '0;
            flush      <= 1'b0;
            ex_mc_done <= 1'b0;
        end else begin
            flush      <= flush_req;
            ex_mc_done <= 1'b0;
            if (flush_req) begin
                // Abort: drop any op in flight and any coincident start.
                state <= IDLE;
                rem   <= '0;
            end else if (state == MC_BUSY) begin
                // ex_mc_start is ignored here: no reload mid-op.
                rem <= rem - ONE;
                if (rem == ONE) begin
                    state      <= IDLE;
                    ex_mc_done <= 1'b1;
                end
            end else if (ex_mc_start) begin
                // The start cycle is itself the first stalled cycle, so only
                // N-1 further cycles remain.
                if (ex_mc_cycles == ONE) begin
                    ex_mc_done <= 1'b1;
                end else if (ex_mc_cycles > ONE) begin
                    rem   <= ex_mc_cycles - ONE;
                    state <= MC_BUSY;
                end
            end
        end
    end

`ifdef STALL_PERF_CNT_EN
    // Saturating count of cycles that hold the PC. stall is already zero
    // during rst, so rst cycles are never counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_perf_cnt <= '0;
        end else if (stall[0] && (stall_perf_cnt != {PERF_W{1'b1}})) begin
            stall_perf_cnt <= stall_perf_cnt + PERF_W'(1);
        end
    end
`else
    assign stall_perf_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// ============================================================================
// tb_pipe_stall_ctrl
// ----------------------------------------------------------------------------
// Directed self-checking bench for pipe_stall_ctrl (MC_CNT_W=6, PERF_W=4).
// Each cyc() call advances one clock, applies that cycle's inputs 1 time unit
// after the rising edge and lets them settle, so the checks that follow see
// the combinational outputs of the current cycle and the registered outputs
// produced by the previous edge. Expected perf-counter values depend on
// whether STALL_PERF_CNT_EN is defined.
// ============================================================================
module tb_pipe_stall_ctrl;

    localparam int MC_CNT_W = 6;
    localparam int PERF_W   = 4;

    localparam logic [5:0] S_EX   = 6'b001111;
    localparam logic [5:0] S_ID   = 6'b000111;
    localparam logic [5:0] S_NONE = 6'b000000;

`ifdef STALL_PERF_CNT_EN
    localparam logic [PERF_W-1:0] PERF_AFTER_1_3 = 4'd6;
    localparam logic [PERF_W-1:0] PERF_SAT       = 4'hF;
`else
    localparam logic [PERF_W-1:0] PERF_AFTER_1_3 = 4'd0;
    localparam logic [PERF_W-1:0] PERF_SAT       = 4'd0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                stallreq_from_id;
    logic                stallreq_from_ex;
    logic                ex_mc_start;
    logic [MC_CNT_W-1:0] ex_mc_cycles;
    logic                flush_req;
    logic [5:0]          stall;
    logic                flush;
    logic                ex_mc_busy;
    logic                ex_mc_done;
    logic [PERF_W-1:0]   stall_perf_cnt;

    int tests  = 0;
    int failed = 0;

    pipe_stall_ctrl #(
        .MC_CNT_W (MC_CNT_W),
        .PERF_W   (PERF_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stallreq_from_id (stallreq_from_id),
        .stallreq_from_ex (stallreq_from_ex),
        .ex_mc_start      (ex_mc_start),
        .ex_mc_cycles     (ex_mc_cycles),
        .flush_req        (flush_req),
        .stall            (stall),
        .flush            (flush),
        .ex_mc_busy       (ex_mc_busy),
        .ex_mc_done       (ex_mc_done),
        .stall_perf_cnt   (stall_perf_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then apply this cycle's inputs.
    task automatic cyc(input logic r, input logic id, input logic ex,
                       input logic st, input logic [MC_CNT_W-1:0] n, input logic fl);
        @(posedge clk);
        #1;
        rst              = r;
        stallreq_from_id = id;
        stallreq_from_ex = ex;
        ex_mc_start      = st;
        ex_mc_cycles     = n;
        flush_req        = fl;
        #1;
    endtask

    initial begin
        rst = 1'b1; stallreq_from_id = 1'b0; stallreq_from_ex = 1'b0;
        ex_mc_start = 1'b0; ex_mc_cycles = '0; flush_req = 1'b0;

        // ---- reset: stall masked even with an EX request present ----
        cyc(1, 0, 1, 0, 0, 0);
        check("rst_stall_masked", 32'(stall), 32'(S_NONE));
        cyc(1, 0, 0, 0, 0, 0);
        check("rst_flush", 32'(flush), 0);
        check("rst_done", 32'(ex_mc_done), 0);
        check("rst_busy", 32'(ex_mc_busy), 0);
        check("rst_perf", 32'(stall_perf_cnt), 0);

        // ---- 1: ID stall for two cycles ----
        cyc(0, 1, 0, 0, 0, 0);
        check("id_stall_c0", 32'(stall), 32'(S_ID));
        check("id_flush_c0", 32'(flush), 0);
        cyc(0, 1, 0, 0, 0, 0);
        check("id_stall_c1", 32'(stall), 32'(S_ID));
        check("id_done_c1", 32'(ex_mc_done), 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("id_release", 32'(stall), 32'(S_NONE));

        // ---- 3: multi-cycle op N=4 ----
        cyc(0, 0, 0, 1, 6'd4, 0);                       // t
        check("mc4_t_stall", 32'(stall), 32'(S_EX));
        check("mc4_t_busy", 32'(ex_mc_busy), 0);
        cyc(0, 0, 0, 0, 0, 0);                          // t+1
        check("mc4_t1_stall", 32'(stall), 32'(S_EX));
        check("mc4_t1_busy", 32'(ex_mc_busy), 1);
        cyc(0, 0, 0, 0, 0, 0);                          // t+2
        check("mc4_t2_stall", 32'(stall), 32'(S_EX));
        check("mc4_t2_done", 32'(ex_mc_done), 0);
        cyc(0, 0, 0, 0, 0, 0);                          // t+3
        check("mc4_t3_stall", 32'(stall), 32'(S_EX));
        check("mc4_t3_busy", 32'(ex_mc_busy), 1);
        check("mc4_t3_done", 32'(ex_mc_done), 0);
        cyc(0, 0, 0, 0, 0, 0);                          // t+4
        check("mc4_t4_stall", 32'(stall), 32'(S_NONE));
        check("mc4_t4_done", 32'(ex_mc_done), 1);
        check("mc4_t4_busy", 32'(ex_mc_busy), 0);
        check("perf_after_1_3", 32'(stall_perf_cnt), 32'(PERF_AFTER_1_3));
        cyc(0, 0, 0, 0, 0, 0);                          // t+5
        check("mc4_t5_done", 32'(ex_mc_done), 0);

        // ---- 3b: N=1 ----
        cyc(0, 0, 0, 1, 6'd1, 0);
        check("mc1_t_stall", 32'(stall), 32'(S_EX));
        cyc(0, 0, 0, 0, 0, 0);
        check("mc1_t1_stall", 32'(stall), 32'(S_NONE));
        check("mc1_t1_done", 32'(ex_mc_done), 1);
        check("mc1_t1_busy", 32'(ex_mc_busy), 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("mc1_t2_done", 32'(ex_mc_done), 0);

        // ---- 3c: N=0 ----
        cyc(0, 0, 0, 1, 6'd0, 0);
        check("mc0_t_stall", 32'(stall), 32'(S_NONE));
        cyc(0, 0, 0, 0, 0, 0);
        check("mc0_t1_done", 32'(ex_mc_done), 0);
        check("mc0_t1_busy", 32'(ex_mc_busy), 0);

        // ---- 2: ID+EX together -> EX-level, bubble at EX/MEM ----
        cyc(0, 1, 1, 0, 0, 0);
        check("idex_stall", 32'(stall), 32'(S_EX));
        check("idex_bubble", {30'b0, stall[4], stall[3]}, 32'b01);
        cyc(0, 0, 1, 0, 0, 0);
        check("ex_only_stall", 32'(stall), 32'(S_EX));

        // ---- 4: N=5 aborted by flush at t+2 ----
        cyc(0, 0, 0, 1, 6'd5, 0);                       // t
        check("fl_t_stall", 32'(stall), 32'(S_EX));
        cyc(0, 0, 0, 0, 0, 0);                          // t+1
        check("fl_t1_busy", 32'(ex_mc_busy), 1);
        cyc(0, 0, 0, 0, 0, 1);                          // t+2
        check("fl_t2_stall", 32'(stall), 32'(S_NONE));
        check("fl_t2_flush", 32'(flush), 0);
        cyc(0, 0, 0, 0, 0, 0);                          // t+3
        check("fl_t3_flush", 32'(flush), 1);
        check("fl_t3_busy", 32'(ex_mc_busy), 0);
        check("fl_t3_stall", 32'(stall), 32'(S_NONE));
        for (int i = 4; i <= 7; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            check($sformatf("fl_t%0d_done", i), 32'(ex_mc_done), 0);
            check($sformatf("fl_t%0d_flush", i), 32'(flush), 0);
        end

        // ---- flush coincident with start drops the start ----
        cyc(0, 0, 0, 1, 6'd3, 1);
        check("flst_stall", 32'(stall), 32'(S_NONE));
        cyc(0, 0, 0, 0, 0, 0);
        check("flst_busy", 32'(ex_mc_busy), 0);
        check("flst_flush", 32'(flush), 1);
        cyc(0, 0, 0, 0, 0, 0);
        check("flst_done", 32'(ex_mc_done), 0);

        // ---- requests honoured in the flush cycle ----
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0);
        check("flcyc_flush", 32'(flush), 1);
        check("flcyc_stall", 32'(stall), 32'(S_ID));

        // ---- 5: re-pulse during a 3-cycle op is ignored ----
        cyc(0, 0, 0, 1, 6'd3, 0);                       // t
        check("rp_t_stall", 32'(stall), 32'(S_EX));
        cyc(0, 0, 0, 1, 6'd6, 0);                       // t+1
        check("rp_t1_stall", 32'(stall), 32'(S_EX));
        check("rp_t1_busy", 32'(ex_mc_busy), 1);
        cyc(0, 1, 0, 0, 0, 0);                          // t+2, ID request overridden
        check("rp_t2_stall", 32'(stall), 32'(S_EX));
        cyc(0, 0, 0, 0, 0, 0);                          // t+3
        check("rp_t3_stall", 32'(stall), 32'(S_NONE));
        check("rp_t3_done", 32'(ex_mc_done), 1);
        check("rp_t3_busy", 32'(ex_mc_busy), 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("rp_t4_done", 32'(ex_mc_done), 0);

        // ---- saturation: 20 EX-stalled cycles on a 4-bit counter ----
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("perf_sat", 32'(stall_perf_cnt), 32'(PERF_SAT));
        cyc(0, 0, 0, 0, 0, 0);
        check("perf_sat_hold", 32'(stall_perf_cnt), 32'(PERF_SAT));

        // ---- rst asserted mid-op ----
        cyc(0, 0, 0, 1, 6'd5, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("rstmid_busy_before", 32'(ex_mc_busy), 1);
        cyc(1, 0, 0, 0, 0, 0);
        check("rstmid_stall", 32'(stall), 32'(S_NONE));
        cyc(0, 0, 0, 0, 0, 0);
        check("rstmid_busy", 32'(ex_mc_busy), 0);
        check("rstmid_perf", 32'(stall_perf_cnt), 0);
        check("rstmid_flush", 32'(flush), 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            check($sformatf("rstmid_done_%0d", i), 32'(ex_mc_done), 0);
            check($sformatf("rstmid_stall_%0d", i), 32'(stall), 32'(S_NONE));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
